// File: rtl/mem_port_arbiter.sv
// Single-ported memory arbiter between instruction-fetch and data ports.
// Define ARB_ROUND_ROBIN_EN to alternate grants on ties; default is fixed data priority.
module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                ip_inst_req,
  input  logic [ADDR_W-1:0]   ip_inst_addr,
  output logic                op_inst_valid,
  output logic [DATA_W-1:0]   op_inst_data,
  input  logic                ip_data_rd,
  input  logic                ip_data_wr,
  input  logic [ADDR_W-1:0]   ip_data_addr,
  input  logic [DATA_W/8-1:0] ip_data_mask,
  input  logic [DATA_W-1:0]   ip_data_wdata,
  output logic                op_data_valid,
  output logic [DATA_W-1:0]   op_data_rdata,
  output logic                op_mem_rd,
  output logic                op_mem_wr,
  output logic [ADDR_W-1:0]   op_mem_addr,
  output logic [DATA_W/8-1:0] op_mem_mask,
  output logic [DATA_W-1:0]   op_mem_wdata,
  input  logic                ip_mem_ready,
  input  logic [DATA_W-1:0]   ip_mem_rdata,
  output logic                op_busy
);

  localparam int MASK_W = DATA_W / 8;

  typedef enum logic [1:0] {IDLE, INST_BUSY, DATA_BUSY} state_t;
  typedef enum logic {GRANT_INST, GRANT_DATA} grant_t;

  state_t state, state_nxt;
  grant_t last_grant;

  logic              inst_req, data_req;
  logic              tie_pick_data;
  logic              grant_inst, grant_data;
  logic              cmd_rd, cmd_wr;
  logic [ADDR_W-1:0] cmd_addr;
  logic [MASK_W-1:0] cmd_mask;
  logic [DATA_W-1:0] cmd_wdata;

  // A port is not re-granted in the cycle its completion pulse is visible.
  always_comb begin
    inst_req = ip_inst_req & ~op_inst_valid;
    data_req = (ip_data_rd | ip_data_wr) & ~op_data_valid;
`ifdef ARB_ROUND_ROBIN_EN
    tie_pick_data = (last_grant == GRANT_INST);
`else
    // Fixed priority: last_grant is tracked but never changes the outcome.
    tie_pick_data = (last_grant == GRANT_INST) | 1'b1;
`endif
    grant_data = (state == IDLE) & data_req & (~inst_req | tie_pick_data);
    grant_inst = (state == IDLE) & inst_req & ~grant_data;
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (grant_data)      state_nxt = DATA_BUSY;
        else if (grant_inst) state_nxt = INST_BUSY;
      end
      INST_BUSY, DATA_BUSY: if (ip_mem_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant    <= GRANT_INST;
      cmd_rd        <= 1'b0;
      cmd_wr        <= 1'b0;
      cmd_addr      <= '0;
      cmd_mask      <= '0;
      cmd_wdata     <= '0;
      op_inst_valid <= 1'b0;
      op_inst_data  <= '0;
      op_data_valid <= 1'b0;
      op_data_rdata <= '0;
    end else begin
      op_inst_valid <= 1'b0;
      op_data_valid <= 1'b0;
      if (grant_data) begin
        last_grant <= GRANT_DATA;
        cmd_rd     <= ip_data_rd;
        cmd_wr     <= ip_data_wr;
        cmd_addr   <= ip_data_addr;
        cmd_mask   <= ip_data_wr ? ip_data_mask : '1;
        cmd_wdata  <= ip_data_wdata;
      end else if (grant_inst) begin
        last_grant <= GRANT_INST;
        cmd_rd     <= 1'b1;
        cmd_wr     <= 1'b0;
        cmd_addr   <= ip_inst_addr;
        cmd_mask   <= '1;
        cmd_wdata  <= '0;
      end
      if (state == INST_BUSY && ip_mem_ready) begin
        op_inst_data  <= ip_mem_rdata;
        op_inst_valid <= 1'b1;
      end
      if (state == DATA_BUSY && ip_mem_ready) begin
        op_data_rdata <= cmd_wr ? '0 : ip_mem_rdata;
        op_data_valid <= 1'b1;
      end
    end
  end

  always_comb begin
    op_busy      = (state != IDLE);
    op_mem_rd    = op_busy & cmd_rd;
    op_mem_wr    = op_busy & cmd_wr;
    op_mem_addr  = cmd_addr;
    op_mem_mask  = cmd_mask;
    op_mem_wdata = cmd_wdata;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed vector table, corner sequences, and a
// randomized run against a transaction-level memory/arbitration model.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        ip_inst_req;
  logic [31:0] ip_inst_addr;
  logic        op_inst_valid;
  logic [31:0] op_inst_data;
  logic        ip_data_rd, ip_data_wr;
  logic [31:0] ip_data_addr;
  logic [3:0]  ip_data_mask;
  logic [31:0] ip_data_wdata;
  logic        op_data_valid;
  logic [31:0] op_data_rdata;
  logic        op_mem_rd, op_mem_wr;
  logic [31:0] op_mem_addr;
  logic [3:0]  op_mem_mask;
  logic [31:0] op_mem_wdata;
  logic        ip_mem_ready;
  logic [31:0] ip_mem_rdata;
  logic        op_busy;

  int checks = 0;
  int errors = 0;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .ip_inst_req(ip_inst_req), .ip_inst_addr(ip_inst_addr),
    .op_inst_valid(op_inst_valid), .op_inst_data(op_inst_data),
    .ip_data_rd(ip_data_rd), .ip_data_wr(ip_data_wr), .ip_data_addr(ip_data_addr),
    .ip_data_mask(ip_data_mask), .ip_data_wdata(ip_data_wdata),
    .op_data_valid(op_data_valid), .op_data_rdata(op_data_rdata),
    .op_mem_rd(op_mem_rd), .op_mem_wr(op_mem_wr), .op_mem_addr(op_mem_addr),
    .op_mem_mask(op_mem_mask), .op_mem_wdata(op_mem_wdata),
    .ip_mem_ready(ip_mem_ready), .ip_mem_rdata(ip_mem_rdata),
    .op_busy(op_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_data;
    bit          wr;
    logic [31:0] addr;
    logic [3:0]  mask;
    logic [31:0] wdata;
    int          lat;
    logic [31:0] mrdata;
    logic [3:0]  exp_mask;
    logic [31:0] exp_res;
  } vec_t;

  vec_t vecs [5];

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ip_inst_req   = 1'b0;
    ip_inst_addr  = '0;
    ip_data_rd    = 1'b0;
    ip_data_wr    = 1'b0;
    ip_data_addr  = '0;
    ip_data_mask  = '0;
    ip_data_wdata = '0;
    ip_mem_ready  = 1'b0;
    ip_mem_rdata  = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    string p;
    p = $sformatf("vec%0d", idx);
    if (v.is_data) begin
      ip_data_rd = !v.wr; ip_data_wr = v.wr; ip_data_addr = v.addr;
      ip_data_mask = v.mask; ip_data_wdata = v.wdata;
    end else begin
      ip_inst_req = 1'b1; ip_inst_addr = v.addr;
    end
    tick();
    for (int k = 1; k <= v.lat; k++) begin
      chk1({p, " busy"}, op_busy, 1'b1);
      chk1({p, " mem_rd"}, op_mem_rd, !v.wr);
      chk1({p, " mem_wr"}, op_mem_wr, v.wr);
      chk32({p, " mem_addr"}, op_mem_addr, v.addr);
      chk32({p, " mem_mask"}, 32'(op_mem_mask), 32'(v.exp_mask));
      if (v.wr) chk32({p, " mem_wdata"}, op_mem_wdata, v.wdata);
      chk1({p, " no early valid"}, op_inst_valid | op_data_valid, 1'b0);
      if (k == v.lat) begin
        ip_mem_ready = 1'b1; ip_mem_rdata = v.mrdata;
      end
      tick();
    end
    idle_inputs();
    chk1({p, " inst_valid"}, op_inst_valid, !v.is_data);
    chk1({p, " data_valid"}, op_data_valid, v.is_data);
    if (v.is_data) chk32({p, " data_rdata"}, op_data_rdata, v.exp_res);
    else           chk32({p, " inst_data"}, op_inst_data, v.exp_res);
    chk1({p, " busy after"}, op_busy, 1'b0);
    chk1({p, " cmd dropped"}, op_mem_rd | op_mem_wr, 1'b0);
    tick();
    chk1({p, " valid one cycle"}, op_inst_valid | op_data_valid, 1'b0);
  endtask

  // Entered in a cycle where a read command must be on the bus; returns in the valid cycle.
  task automatic expect_access(input bit is_data, input logic [31:0] addr,
                               input logic [31:0] rdata, input string nm);
    chk1({nm, " mem_rd"}, op_mem_rd, 1'b1);
    chk32({nm, " mem_addr"}, op_mem_addr, addr);
    ip_mem_ready = 1'b1; ip_mem_rdata = rdata;
    tick();
    ip_mem_ready = 1'b0;
    chk1({nm, " inst_valid"}, op_inst_valid, !is_data);
    chk1({nm, " data_valid"}, op_data_valid, is_data);
    if (is_data) begin
      chk32({nm, " rdata"}, op_data_rdata, rdata);
      ip_data_rd = 1'b0;
    end else begin
      chk32({nm, " idata"}, op_inst_data, rdata);
      ip_inst_req = 1'b0;
    end
  endtask

  task automatic post_tie(input logic [31:0] ia, input logic [31:0] da);
    ip_inst_req = 1'b1; ip_inst_addr = ia;
    ip_data_rd = 1'b1; ip_data_addr = da;
  endtask

  task automatic lone(input bit is_data, input logic [31:0] addr, input logic [31:0] rdata,
                      input string nm);
    if (is_data) begin ip_data_rd = 1'b1; ip_data_addr = addr; end
    else         begin ip_inst_req = 1'b1; ip_inst_addr = addr; end
    tick();
    expect_access(is_data, addr, rdata, nm);
    tick();
  endtask

  task automatic random_test(input int ncyc);
    logic [31:0] mem [16];
    bit pi, pd, pwr, busy, prev_idle, prev_ri, prev_rd, exp_vi, exp_vd, vi_now, vd_now;
    bit srv_data, last_data, take_data, c_rd, c_wr;
    logic [31:0] ia, da, dw, exp_id, exp_dd, c_addr, c_wdata, res;
    logic [3:0] dm, c_mask;
    int lat;
    for (int i = 0; i < 16; i++) mem[i] = $urandom;
    pi = 0; pd = 0; pwr = 0; busy = 0; prev_idle = 1; prev_ri = 0; prev_rd = 0;
    exp_vi = 0; exp_vd = 0; srv_data = 0; last_data = 0; lat = 0;
    ia = '0; da = '0; dw = '0; dm = '0; exp_id = '0; exp_dd = '0;
    c_rd = 0; c_wr = 0; c_addr = '0; c_wdata = '0; c_mask = '0;
    for (int c = 0; c < ncyc; c++) begin
      vi_now = exp_vi; vd_now = exp_vd;
      chk1("rnd inst_valid", op_inst_valid, exp_vi);
      chk1("rnd data_valid", op_data_valid, exp_vd);
      if (exp_vi) begin chk32("rnd inst_data", op_inst_data, exp_id); pi = 0; end
      if (exp_vd) begin chk32("rnd data_rdata", op_data_rdata, exp_dd); pd = 0; end
      exp_vi = 0; exp_vd = 0;
      if (prev_idle && (prev_ri || prev_rd)) begin
`ifdef ARB_ROUND_ROBIN_EN
        take_data = prev_rd && (!prev_ri || !last_data);
`else
        take_data = prev_rd;
`endif
        busy = 1; srv_data = take_data; last_data = take_data;
        lat = $urandom_range(1, 4);
        if (take_data) begin
          c_rd = !pwr; c_wr = pwr; c_addr = da; c_wdata = dw; c_mask = pwr ? dm : 4'hf;
        end else begin
          c_rd = 1; c_wr = 0; c_addr = ia; c_wdata = '0; c_mask = 4'hf;
        end
      end
      chk1("rnd busy", op_busy, busy);
      if (busy) begin
        chk1("rnd mem_rd", op_mem_rd, c_rd);
        chk1("rnd mem_wr", op_mem_wr, c_wr);
        chk32("rnd mem_addr", op_mem_addr, c_addr);
        chk32("rnd mem_mask", 32'(op_mem_mask), 32'(c_mask));
        if (c_wr) chk32("rnd mem_wdata", op_mem_wdata, c_wdata);
      end else begin
        chk1("rnd idle cmd", op_mem_rd | op_mem_wr, 1'b0);
      end
      prev_idle = !busy;
      ip_mem_rdata = $urandom;
      if (busy) begin
        lat--;
        ip_mem_ready = (lat == 0);
        if (lat == 0) begin
          if (c_wr) begin
            for (int b = 0; b < 4; b++)
              if (c_mask[b]) mem[c_addr[5:2]][8*b +: 8] = c_wdata[8*b +: 8];
            res = '0;
          end else begin
            res = mem[c_addr[5:2]];
            ip_mem_rdata = res;
          end
          if (srv_data) begin exp_vd = 1; exp_dd = res; end
          else          begin exp_vi = 1; exp_id = res; end
          busy = 0;
        end
      end else begin
        ip_mem_ready = ($urandom_range(0, 3) == 0);
      end
      if (!pi && $urandom_range(0, 2) == 0) begin
        pi = 1; ia = {26'b0, 4'($urandom), 2'b00};
      end
      if (!pd && $urandom_range(0, 2) == 0) begin
        pd = 1; pwr = 1'($urandom); da = {26'b0, 4'($urandom), 2'b00};
        dm = 4'($urandom); dw = $urandom;
      end
      ip_inst_req = pi; ip_inst_addr = ia;
      ip_data_rd = pd && !pwr; ip_data_wr = pd && pwr;
      ip_data_addr = da; ip_data_mask = dm; ip_data_wdata = dw;
      prev_ri = pi && !vi_now;
      prev_rd = pd && !vd_now;
      tick();
    end
  endtask

  initial begin
    vecs[0] = '{0, 0, 32'h0000_0100, 4'h0, 32'h0,         1, 32'h0000_0013, 4'hf, 32'h0000_0013};
    vecs[1] = '{1, 1, 32'h0000_0204, 4'h4, 32'h00AB_0000, 3, 32'hDEAD_BEEF, 4'h4, 32'h0};
    vecs[2] = '{1, 0, 32'h0000_0040, 4'h0, 32'h1111_1111, 2, 32'hCAFE_F00D, 4'hf, 32'hCAFE_F00D};
    vecs[3] = '{0, 0, 32'hFFFF_FFFC, 4'h0, 32'h0,         4, 32'hFFFF_FFFF, 4'hf, 32'hFFFF_FFFF};
    vecs[4] = '{1, 1, 32'h0000_0010, 4'hf, 32'h1234_5678, 1, 32'h0BAD_0BAD, 4'hf, 32'h0};

    idle_inputs();
    reset = 1'b1;
    tick();
    tick();
    chk1("reset busy", op_busy, 1'b0);
    chk1("reset mem_rd", op_mem_rd, 1'b0);
    chk1("reset mem_wr", op_mem_wr, 1'b0);
    chk32("reset mem_addr", op_mem_addr, 32'h0);
    chk32("reset mem_mask", 32'(op_mem_mask), 32'h0);
    chk1("reset valids", op_inst_valid | op_data_valid, 1'b0);
    chk32("reset inst_data", op_inst_data, 32'h0);
    chk32("reset data_rdata", op_data_rdata, 32'h0);
    reset = 1'b0;
    tick();

    for (int i = 0; i < 5; i++) run_vec(vecs[i], i);

`ifndef ARB_ROUND_ROBIN_EN
    for (int r = 0; r < 3; r++) begin
      post_tie(32'h8, 32'h40);
      tick();
      expect_access(1, 32'h40, 32'h1000 + r, "tie data first");
      tick();
      expect_access(0, 32'h8, 32'h2000 + r, "tie inst second");
      tick();
      chk1("tie idle", op_busy, 1'b0);
    end
`else
    do_reset();
    post_tie(32'h8, 32'h40);
    tick();
    expect_access(1, 32'h40, 32'h3000, "rr tie1 data");
    tick();
    expect_access(0, 32'h8, 32'h3001, "rr tie1 inst");
    tick();
    lone(1, 32'h44, 32'h3002, "rr lone data");
    post_tie(32'hC, 32'h48);
    tick();
    expect_access(0, 32'hC, 32'h3003, "rr tie2 inst");
    tick();
    expect_access(1, 32'h48, 32'h3004, "rr tie2 data");
    tick();
    lone(0, 32'h10, 32'h3005, "rr lone inst");
    post_tie(32'h14, 32'h4C);
    tick();
    expect_access(1, 32'h4C, 32'h3006, "rr tie3 data");
    tick();
    expect_access(0, 32'h14, 32'h3007, "rr tie3 inst");
    tick();
`endif

    ip_data_rd = 1'b1; ip_data_addr = 32'h40;
    tick();
    chk32("stable addr c1", op_mem_addr, 32'h40);
    ip_data_addr = 32'h80; ip_data_rd = 1'b0; ip_data_wr = 1'b1;
    tick();
    chk32("stable addr c2", op_mem_addr, 32'h40);
    chk1("stable rd c2", op_mem_rd, 1'b1);
    chk1("stable wr c2", op_mem_wr, 1'b0);
    tick();
    chk32("stable addr c3", op_mem_addr, 32'h40);
    ip_mem_ready = 1'b1; ip_mem_rdata = 32'h7777_0000;
    tick();
    idle_inputs();
    chk1("stable valid", op_data_valid, 1'b1);
    chk32("stable rdata", op_data_rdata, 32'h7777_0000);
    tick();

    ip_data_wr = 1'b1; ip_data_addr = 32'h300; ip_data_mask = 4'h3; ip_data_wdata = 32'hABCD;
    tick();
    tick();
    chk1("rst-mid busy before", op_busy, 1'b1);
    reset = 1'b1;
    tick();
    chk1("rst-mid mem_wr", op_mem_wr, 1'b0);
    chk1("rst-mid busy", op_busy, 1'b0);
    chk1("rst-mid no valid", op_data_valid, 1'b0);
    reset = 1'b0;
    idle_inputs();
    ip_mem_ready = 1'b1; ip_mem_rdata = 32'h5555_5555;
    tick();
    ip_mem_ready = 1'b0;
    chk1("late ready no valid", op_data_valid, 1'b0);
    chk1("late ready busy", op_busy, 1'b0);
    tick();
    chk1("late ready no valid2", op_data_valid | op_inst_valid, 1'b0);
    chk32("late ready rdata", op_data_rdata, 32'h0);

    do_reset();
    tick();
    random_test(3000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
